// File: rtl/cxl_ar_arbiter.sv
// cxl_ar_arbiter
//   Shares the CXL-controller AR channel between the cache fill path (req0)
//   and the prefetch engine (req1).
//   - Fixed priority to req0. req1 is forced after STARVE_LIMIT consecutive
//     req0 grants while it was waiting.
//   - Each issued read is logged into the RMiss FIFO at its AR handshake.
//   - In-flight reads are limited by a credit counter. A credit is returned
//     on every R last beat.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req0_valid_i/ready_o    fill request handshake (ready is a combinational grant pulse)
//   req0_data_i             {tid, addr} of the fill request
//   req1_valid_i/ready_o    prefetch request handshake
//   req1_data_i             {tid, addr} of the prefetch request
//   arid_o, araddr_o        AR payload toward the CXL controller; arid = {ID[ID_WIDTH-1:1], src}
//   arvalid_o, arready_i    AR handshake
//   rvalid_i/rready_i/rlast_i  R channel, monitored only to return credits
//   rmfifo_afull_i          RMiss FIFO almost full; blocks new grants
//   rmfifo_wren_o/data_o    RMiss FIFO write of the issued {tid, addr}
//
// Optional build macro
//   CXL_AR_PERF_EN adds perf_fill_cnt_o, perf_pf_cnt_o and perf_stall_cnt_o.
//   These are free-running 32-bit event counters.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif

module cxl_ar_arbiter #(
  parameter int                  ADDR_WIDTH      = `AXI_ADDR_WIDTH,
  parameter int                  ID_WIDTH        = `AXI_ID_WIDTH,
  parameter logic [ID_WIDTH-1:0] ID              = ID_WIDTH'(`AXI_ID),
  parameter int                  TID_WIDTH       = `TID_WIDTH,
  parameter int                  MAX_OUTSTANDING = 8,
  parameter int                  STARVE_LIMIT    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req0_valid_i,
  output logic                            req0_ready_o,
  input  logic [TID_WIDTH+ADDR_WIDTH-1:0] req0_data_i,
  input  logic                            req1_valid_i,
  output logic                            req1_ready_o,
  input  logic [TID_WIDTH+ADDR_WIDTH-1:0] req1_data_i,
  output logic [ID_WIDTH-1:0]             arid_o,
  output logic [ADDR_WIDTH-1:0]           araddr_o,
  output logic                            arvalid_o,
  input  logic                            arready_i,
  input  logic                            rvalid_i,
  input  logic                            rready_i,
  input  logic                            rlast_i,
  input  logic                            rmfifo_afull_i,
  output logic                            rmfifo_wren_o,
  output logic [TID_WIDTH+ADDR_WIDTH-1:0] rmfifo_data_o
`ifdef CXL_AR_PERF_EN
  ,
  output logic [31:0]                     perf_fill_cnt_o,
  output logic [31:0]                     perf_pf_cnt_o,
  output logic [31:0]                     perf_stall_cnt_o
`endif
);

  localparam int DW = TID_WIDTH + ADDR_WIDTH;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                state_q;
  logic [CW-1:0]         outst_q, outst_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [DW-1:0]         data_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic                  wren_q;
  logic [DW-1:0]         rmdata_q;

  logic          credit_ok;
  logic          any_req;
  logic          grant;
  logic          win1;
  logic [DW-1:0] win_data;
  logic          ar_hs;
  logic          r_last;

  assign credit_ok = (outst_q < MAX_CNT);
  assign any_req   = req0_valid_i | req1_valid_i;
  // Gated by rst_n so that no ready pulse leaks out while reset is held.
  assign grant     = rst_n && (state_q == S_IDLE) && credit_ok && !rmfifo_afull_i && any_req;
  assign win1      = req1_valid_i && (!req0_valid_i || (starve_q >= STARVE_MAX));
  assign win_data  = win1 ? req1_data_i : req0_data_i;

  assign req0_ready_o = grant & ~win1;
  assign req1_ready_o = grant & win1;

  // arvalid_q is only ever high in S_ISSUE.
  assign ar_hs  = arvalid_q & arready_i;
  assign r_last = rvalid_i & rready_i & rlast_i;

  // A credit taken and a credit returned in the same cycle cancel out.
  // Grants stop at MAX_CNT, so the increment can never overflow.
  always_comb begin
    outst_d = outst_q;
    if (ar_hs && !r_last) begin
      outst_d = outst_q + CW'(1);
    end else if (!ar_hs && r_last && (outst_q != '0)) begin
      outst_d = outst_q - CW'(1);
    end
  end

  // The starve counter counts req0 wins over a waiting req1. It restarts
  // whenever req1 is served or stops asking.
  always_comb begin
    starve_d = starve_q;
    if (!req1_valid_i || (grant && win1)) begin
      starve_d = '0;
    end else if (grant && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      outst_q   <= '0;
      starve_q  <= '0;
      data_q    <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      wren_q    <= 1'b0;
      rmdata_q  <= '0;
    end else begin
      outst_q  <= outst_d;
      starve_q <= starve_d;
      wren_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            data_q    <= win_data;
            arvalid_q <= 1'b1;
            araddr_q  <= win_data[ADDR_WIDTH-1:0];
            arid_q    <= {ID[ID_WIDTH-1:1], win1};
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The AR payload stays frozen until the handshake.
          // The RMiss FIFO afull check was done at grant time. Its margin
          // covers this one write.
          if (arready_i) begin
            arvalid_q <= 1'b0;
            wren_q    <= 1'b1;
            rmdata_q  <= data_q;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arvalid_o     = arvalid_q;
  assign araddr_o      = araddr_q;
  assign arid_o        = arid_q;
  assign rmfifo_wren_o = wren_q;
  assign rmfifo_data_o = rmdata_q;

`ifndef SYNTHESIS
  // A credit return with nothing outstanding points to an upstream protocol bug.
  always_ff @(posedge clk) begin
    if (rst_n && r_last && !ar_hs) begin
      assert (outst_q != '0)
      else $error("cxl_ar_arbiter: R last beat received with no reads outstanding");
    end
  end
`endif

`ifdef CXL_AR_PERF_EN
  logic [31:0] fill_cnt_q;
  logic [31:0] pf_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt_q  <= '0;
      pf_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      // arid_q[0] holds the latched source of the read in flight.
      if (ar_hs && arid_q[0]) begin
        pf_cnt_q <= pf_cnt_q + 32'd1;
      end
      if (ar_hs && !arid_q[0]) begin
        fill_cnt_q <= fill_cnt_q + 32'd1;
      end
      if ((state_q == S_IDLE) && any_req && (!credit_ok || rmfifo_afull_i)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fill_cnt_o  = fill_cnt_q;
  assign perf_pf_cnt_o    = pf_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/cxl_ar_arbiter.md
Name: cxl_ar_arbiter

Overview:
Shares the single CXL-controller AR channel between two read requesters: the cache fill path (req0, read misses) and the prefetch engine (req1).
- Grants one request at a time under a fixed-priority policy with starvation protection.
- Drives the AXI AR handshake toward the CXL controller.
- Logs every issued read into the RMiss FIFO.
- Limits the number of outstanding reads with a credit counter that is returned on R-channel last beats.

Parameters:
ADDR_WIDTH, `AXI_ADDR_WIDTH, address width
ID_WIDTH, `AXI_ID_WIDTH, AXI ID width (>=2)
ID, `AXI_ID, base AXI ID; bit 0 is overridden with the source
TID_WIDTH, `TID_WIDTH, transaction tag width
MAX_OUTSTANDING, 8, max in-flight reads (power of 2 not required, >=1)
STARVE_LIMIT, 4, consecutive req0 grants while req1 waits before req1 is forced

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req0_valid_i  input  1  fill request valid
req0_ready_o  output  1  fill request accepted (grant pulse)
req0_data_i  input  TID_WIDTH+ADDR_WIDTH  {tid, addr} of fill
req1_valid_i  input  1  prefetch request valid
req1_ready_o  output  1  prefetch request accepted
req1_data_i  input  TID_WIDTH+ADDR_WIDTH  {tid, addr} of prefetch
arid_o  output  ID_WIDTH  {ID[ID_WIDTH-1:1], src}
araddr_o  output  ADDR_WIDTH  read address
arvalid_o  output  1  AR valid
arready_i  input  1  AR ready
rvalid_i  input  1  R valid (credit return monitor)
rready_i  input  1  R ready
rlast_i  input  1  R last beat
rmfifo_afull_i  input  1  RMiss FIFO almost full
rmfifo_wren_o  output  1  RMiss FIFO write
rmfifo_data_o  output  TID_WIDTH+ADDR_WIDTH  {tid, addr} of issued read

Behaviour:
- Reset: rst_n is synchronous and active-low on clk. On reset: state=S_IDLE, all outputs 0, outstanding=0, starve=0, latched request=0.
- Grant condition in S_IDLE, evaluated every cycle: outstanding<MAX_OUTSTANDING && !rmfifo_afull_i && (req0_valid_i || req1_valid_i).
- Winner selection:
  - req1 wins if req1_valid_i && (!req0_valid_i || starve>=STARVE_LIMIT).
  - Otherwise req0 wins.
- On grant:
  - Pulse the winner's reqN_ready_o for exactly that cycle (combinational, valid&ready handshake).
  - Latch data and src (0=fill, 1=prefetch).
  - Go to S_ISSUE.
  - No ready is asserted outside S_IDLE or when the grant condition is false.
- Starve counter:
  - +1 when req0 is granted while req1_valid_i=1; saturates at STARVE_LIMIT.
  - Cleared when req1 is granted or when req1_valid_i=0.
- S_ISSUE:
  - arvalid_o=1; araddr_o and arid_o come from the latched values and are held stable until arready_i.
  - When arready_i=1: rmfifo_wren_o=1 for one cycle with rmfifo_data_o=latched {tid, addr}; outstanding+1; next state S_IDLE.
  - rmfifo_afull_i is not rechecked in S_ISSUE; the almost-full margin covers one write.
- Latency: request grant to earliest arvalid_o = 1 cycle. Back-to-back issue rate is one read every 2 cycles.
- Credit counter update:
  - −1 on rvalid_i&rready_i&rlast_i.
  - Simultaneous AR handshake and R last: counter unchanged.
  - Decrement at 0 is ignored (simulation assertion flags it).
  - The counter never exceeds MAX_OUTSTANDING.
- Reset mid-transaction: an AR in progress is abandoned; arvalid_o drops the next cycle. Requesters re-present their requests.

Optional Feature:
CXL_AR_PERF_EN:
- When defined, adds output ports perf_fill_cnt_o[31:0], perf_pf_cnt_o[31:0] and perf_stall_cnt_o[31:0].
- perf_fill_cnt_o and perf_pf_cnt_o count AR handshakes per src.
- perf_stall_cnt_o counts cycles where any request is valid but the grant is blocked by credits or rmfifo_afull_i.
- Counters wrap at 2^32 and clear on reset.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single fill: req0 {tid=3, addr=0x1000}, arready_i=1 -> req0_ready_o pulse at cycle 0, arvalid_o at cycle 1 with araddr=0x1000, arid bit0=0, rmfifo_wren_o with data {3, 0x1000}, outstanding=1.
- Backpressure: arready_i=0 for 5 cycles -> arvalid_o, araddr_o and arid_o held constant; no rmfifo write until arready_i=1.
- Credit limit (MAX_OUTSTANDING=8): issue 8 reads with no R -> 9th request not granted; one R beat with rlast=1 -> grant the next cycle.
- Starvation (STARVE_LIMIT=4): req0 and req1 both valid continuously -> grant order is req0 ×4, then req1 (arid bit0=1), then req0.
- RMiss full: rmfifo_afull_i=1 with req0 valid -> no ready and arvalid_o=0; deassert -> grant the next cycle.
- Simultaneous AR handshake and R last at outstanding=3 -> stays 3. Reset asserted during S_ISSUE -> arvalid_o=0 and outstanding=0 on the following cycle.
